// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes RV32 load/store size and alignment, issues a single
// word-aligned memory request, waits for ack or timeout, then retires with an extended load result.
module lsu_ctrl #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req,
    input  logic        st_req,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  l_length,
    input  logic [1:0]  s_length,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_bmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        fault,
    output logic        tmo,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, uns_q, is_ld_q;
    logic [31:0] addr_q, wdata_q, ld_data_q;
    logic [3:0]  bmask_q;
    logic [1:0]  off_q, size_q;
    logic [7:0]  cnt_q;

    logic        any_req, len_ok, align_ok, req_ok, accept, tmo_hit;
    logic [1:0]  req_size;
    logic [3:0]  st_bmask;
    logic [31:0] st_wdata, ld_ext;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Load wins when both request lines are set; the store is silently dropped.
    always_comb begin
        any_req  = ld_req | st_req;
        req_size = ld_req ? l_length[1:0] : s_length;
        len_ok   = ld_req ? (l_length inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                          : (s_length != 2'b11);
        case (req_size)
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = ~addr[0];
            2'd2:    align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        req_ok = len_ok & align_ok;
    end

    always_comb begin
        case (s_length)
            2'b00: begin
                st_bmask = 4'b0001 << addr[1:0];
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_bmask = 4'b0011 << {addr[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_bmask = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    ld_ext = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    ld_ext = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    assign tmo_hit = (cnt_q == 8'(TMO_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        stall    = 1'b0;
        fault    = 1'b0;
        tmo      = 1'b0;
        mem_req  = 1'b0;
        ld_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    if (req_ok) begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    tmo     = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ld_valid = is_ld_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            is_ld_q   <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            bmask_q   <= 4'd0;
            off_q     <= 2'd0;
            size_q    <= 2'd0;
            cnt_q     <= 8'd0;
            ld_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= ~ld_req;
                is_ld_q <= ld_req;
                uns_q   <= ld_req & l_length[2];
                addr_q  <= {addr[31:2], 2'b00};
                wdata_q <= ld_req ? 32'd0 : st_wdata;
                bmask_q <= ld_req ? 4'b1111 : st_bmask;
                off_q   <= addr[1:0];
                size_q  <= req_size;
                cnt_q   <= 8'd0;
            end
            // Ack takes precedence over a timeout landing in the same cycle.
            if (state_q == S_WAIT) begin
                if (mem_ack) begin
                    if (is_ld_q) ld_data_q <= ld_ext;
                end else if (tmo_hit) begin
                    ld_data_q <= 32'd0;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_bmask = bmask_q;
    assign ld_data   = ld_data_q;
    assign dbg_state = state_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TMO_CYCLES, default 255, maximum WAIT cycles without mem_ack before timeout (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ld_req  input  1  load instruction present this cycle.
REQ-005 st_req  input  1  store instruction present this cycle.
REQ-006 addr  input  32  effective byte address from ALU.
REQ-007 st_data  input  32  store source (rs2).
REQ-008 l_length  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 s_length  input  2  store size: 00 SB, 01 SH, 10 SW.
REQ-010 mem_req  output  1  memory request, held until mem_ack.
REQ-011 mem_we  output  1  1 = write, 0 = read.
REQ-012 mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 mem_wdata  output  32  lane-replicated store data.
REQ-014 mem_bmask  output  4  byte-lane enables.
REQ-015 mem_rdata  input  32  read data, valid with mem_ack.
REQ-016 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-017 stall  output  1  holds PC/instruction while access outstanding.
REQ-018 ld_data  output  32  extended load result.
REQ-019 ld_valid  output  1  ld_data valid (writeback enable qualifier).
REQ-020 fault  output  1  one-cycle pulse: misaligned or illegal size.
REQ-021 tmo  output  1  one-cycle pulse: access timed out.

Function
REQ-022 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-023 IDLE: ld_req has priority over st_req when both set; store dropped, no fault.
REQ-024 IDLE accept check: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, l_length in {011,110,111}, or s_length=11 -> fault=1 same cycle, no mem_req, stall=0, remain IDLE.
REQ-025 IDLE valid request: stall=1 combinationally same cycle; latch addr[1:0], size, unsigned flag, direction, mem_addr, mem_wdata, mem_bmask; next state WAIT; timeout counter cleared to 0.
REQ-026 WAIT: mem_req=1, stall=1, registered mem_* outputs stable until mem_ack.
REQ-027 WAIT + mem_ack: loads capture extracted mem_rdata into ld_data; next state DONE; counter ignored that cycle.
REQ-028 WAIT without ack: counter increments; when counter reaches TMO_CYCLES-1 without ack, tmo=1 for that cycle, ld_data=0, next DONE.
REQ-029 DONE: stall=0, mem_req=0, ld_valid=1 only if latched access was a load; ld_req/st_req ignored (same instruction retiring); next IDLE.
REQ-030 Access latency: ack in nth WAIT cycle -> ld_valid in cycle n+2 after acceptance; minimum 3 cycles per access.
REQ-031 Store mask: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; load mask 4'b1111, mem_we=0.
REQ-032 Store data: SB {4{st_data[7:0]}}; SH {2{st_data[15:0]}}; SW st_data.
REQ-033 Load extract: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unchanged.
REQ-034 mem_ack in IDLE or DONE ignored, no state change, no output effect.
REQ-035 ld_data holds last value outside DONE; ld_valid, fault, tmo are 0 except as stated.

Reset
REQ-036 rst=1 at a rising edge: state IDLE, counter 0, all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_bmask, stall, ld_data, ld_valid, fault, tmo) next cycle.
REQ-037 rst during WAIT abandons the access: mem_req=0 next cycle; late mem_ack afterwards ignored per REQ-034.
REQ-038 rst has priority over every concurrent request or ack.

Verification
REQ-039 LB addr=0x103, mem_rdata=0x80FF_1234, ack in 2nd WAIT cycle -> mem_addr=0x100, bmask=1111, ld_data=0xFFFF_FF80, ld_valid in DONE only.
REQ-040 SH addr=0x202, st_data=0x1234_ABCD -> mem_we=1, mem_addr=0x200, bmask=1100, mem_wdata=0xABCD_ABCD; ld_valid stays 0.
REQ-041 LW addr=0x101 -> fault=1 one cycle, mem_req=0, stall=0; l_length=011 at aligned addr -> same.
REQ-042 LHU addr=0x0, mem_ack never asserted, TMO_CYCLES=255 -> tmo=1 in 255th WAIT cycle, ld_data=0, DONE then IDLE.
REQ-043 ld_req=st_req=1 -> load issued (mem_we=0); rst asserted during WAIT -> mem_req=0 next cycle, subsequent ack ignored.
REQ-044 Back-to-back SB then LBU same word: second request accepted only in IDLE after DONE; stall drops exactly in each DONE cycle.
